// File: rtl/sar_if.sv
// Comparator-side bundle for the successive-approximation search controller.
// master = the controller, slave = comparator/requester side.
interface sar_if #(
    parameter int N = 4
);
    logic         start;
    logic         GT;
    logic         LT;
    logic         EQ;
    logic [N-1:0] trial;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        input  start, GT, LT, EQ,
        output trial, result, busy, done, err
    );

    modport slave (
        output start, GT, LT, EQ,
        input  trial, result, busy, done, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation controller: drives trial values into a magnitude
// comparator and resolves one bit per cycle, MSB first.
//
// state  | meaning
// IDLE   | waiting for start, trial held at 0
// SEARCH | one bit resolved per edge, idx counts down from N-1
module sar_search #(
    parameter int N = 4
) (
    input  logic  clk,
    input  logic  rst,
    sar_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  trial_q, trial_n;
    logic [N-1:0]  result_q, result_n;
    logic [IW-1:0] idx_q, idx_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          keep;
    logic          onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IW'(N - 1);
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            trial_q  <= trial_n;
            result_q <= result_n;
            idx_q    <= idx_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        trial_n  = trial_q;
        result_n = result_q;
        idx_n    = idx_q;
        done_n   = 1'b0;
        err_n    = err_q;
        // Contradictory flags still resolve through keep; err only records them.
        keep     = (bus.GT | bus.EQ) & ~bus.LT;
        onehot   = ({bus.GT, bus.LT, bus.EQ} == 3'b100) ||
                   ({bus.GT, bus.LT, bus.EQ} == 3'b010) ||
                   ({bus.GT, bus.LT, bus.EQ} == 3'b001);
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SEARCH;
                    trial_n = {1'b1, {(N-1){1'b0}}};
                    idx_n   = IW'(N - 1);
                    err_n   = 1'b0;
                end
            end
            SEARCH: begin
                trial_n[idx_q] = keep;
                if (!onehot) begin
                    err_n = 1'b1;
                end
                if (idx_q != '0) begin
                    trial_n[idx_q - IW'(1)] = 1'b1;
                    idx_n = idx_q - IW'(1);
                end else begin
                    result_n = trial_n;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                    trial_n  = '0;
                    idx_n    = IW'(N - 1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.trial  = trial_q;
    assign bus.result = result_q;
    assign bus.busy   = (state == SEARCH);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: comparator modelled in the bench, expected trial
// sequences derived from a plain binary-search reference.
module tb_sar_search;
    localparam int N = 4;

    logic clk;
    logic rst;
    sar_if #(.N(N)) bus ();

    sar_search #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] target;
    logic         bad;
    int           passed;
    int           failed;
    int           total;
    int           cyc;
    int           last_done_cyc;
    bit           pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator: a = target, b = trial, cascade tied for "equal so far".
    assign bus.GT = bad ? 1'b0 : (target > bus.trial);
    assign bus.LT = bad ? 1'b0 : (target < bus.trial);
    assign bus.EQ = bad ? 1'b0 : (target == bus.trial);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bad_k: trial step during which flags read 000; dup_k: step during which
    // start is re-pulsed; chain: raise start in the done cycle with next_tgt.
    task automatic search(input logic [N-1:0] tgt, input int bad_k, input int dup_k,
                          input bit chain, input logic [N-1:0] next_tgt);
        logic [N-1:0] exp_trial [N];
        logic [N-1:0] v;
        logic [N-1:0] t;
        if (!pending) begin
            target    = tgt;
            bus.start = 1'b1;
        end
        pending = 1'b0;
        v = '0;
        for (int k = 0; k < N; k++) begin
            t = v | (N'(1) << (N - 1 - k));
            exp_trial[k] = t;
            if ((k != bad_k) && (target >= t)) v = t;
        end
        tick();
        bus.start = 1'b0;
        chk("err_cleared_on_start", 32'(bus.err), 32'd0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("trial_step%0d", k), 32'(bus.trial), 32'(exp_trial[k]));
            chk("busy_in_search", 32'(bus.busy), 32'd1);
            chk("no_done_in_search", 32'(bus.done), 32'd0);
            bad       = (k == bad_k);
            bus.start = (k == dup_k);
            tick();
        end
        bad       = 1'b0;
        bus.start = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("result", 32'(bus.result), 32'(v));
        chk("err_at_done", 32'(bus.err), (bad_k >= 0) ? 32'd1 : 32'd0);
        chk("busy_low_at_done", 32'(bus.busy), 32'd0);
        chk("trial_zero_at_done", 32'(bus.trial), 32'd0);
        if (last_done_cyc >= 0 && pending == 1'b0 && chain == 1'b0 && dup_k == -2) begin
            chk("b2b_spacing", 32'(cyc - last_done_cyc), 32'd5);
        end
        last_done_cyc = cyc;
        if (chain) begin
            target    = next_tgt;
            bus.start = 1'b1;
            pending   = 1'b1;
        end else begin
            tick();
            chk("done_falls", 32'(bus.done), 32'd0);
            chk("idle_after_done", 32'(bus.busy), 32'd0);
            if (dup_k >= 0) begin
                for (int i = 0; i < N + 1; i++) begin
                    tick();
                    chk("no_second_done", 32'(bus.done), 32'd0);
                    chk("no_requeue_busy", 32'(bus.busy), 32'd0);
                end
            end
        end
    endtask

    initial begin
        passed = 0; failed = 0; total = 0; cyc = 0;
        last_done_cyc = -1;
        pending = 1'b0;
        bad = 1'b0;
        target = '0;
        bus.start = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_trial", 32'(bus.trial), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // Release reset with start already high: first free edge accepts it.
        target = 4'b1011;
        bus.start = 1'b1;
        #4 rst = 1'b0;
        pending = 1'b1;
        search(4'b1011, -1, -1, 1'b0, '0);

        search(4'b0000, -1, -1, 1'b0, '0);
        search(4'b1111, -1, -1, 1'b0, '0);

        // start re-pulsed during cycle 2 of the search.
        search(4'b0110, -1, 1, 1'b0, '0);

        // Back-to-back: start held through the done cycle.
        search(4'b0101, -1, -1, 1'b1, 4'b1001);
        search(4'b1001, -1, -2, 1'b0, '0);

        // Async reset between edges during cycle 2.
        target = 4'b1101;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_trial", 32'(bus.trial), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        search(4'b1101, -1, -1, 1'b0, '0);

        // Malformed flags on cycle 2, then cleared by the next start.
        search(4'b1110, 1, -1, 1'b0, '0);
        search(4'b0011, -1, -1, 1'b0, '0);

        for (int r = 0; r < 24; r++) begin
            logic [N-1:0] tg;
            int bk;
            tg = N'($urandom_range(0, (1 << N) - 1));
            bk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            search(tg, bk, -1, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
